majority_vote_scheduler: RTL and testbench
==========================================

Name: majority_vote_scheduler

Overview:
- Shares one bit-serial 7-input majority evaluator among NUM_REQ requesters.
- A round-robin arbiter grants one requester at a time and captures its vote word. The block counts ones serially over VOTE_W cycles, then returns the majority decision tagged with the requester id.
- Sits between vote sources (sensor/channel voters) and the downstream consumer of majority decisions.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- VOTE_W, 7, bits per vote word (odd, >=3).
- THRESH, (VOTE_W+1)/2 = 4, ones-count at or above which res_out=1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester vote word available.
- req_data  input  NUM_REQ*VOTE_W  vote words; requester i occupies bits [i*VOTE_W +: VOTE_W].
- req_ready  output  NUM_REQ  one-hot grant/accept strobe.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_out  output  1  majority decision.
- res_id  output  ID_W=$clog2(NUM_REQ)  requester that produced the result.
- res_count  output  CNT_W=$clog2(VOTE_W+1)  ones count of the vote word.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset, when rst_n=0 at a clk edge:
  - state=IDLE; req_ready=0, res_valid=0, res_out=0, res_id=0, res_count=0, busy=0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-SCAN or mid-DONE abandons the transaction; no result is emitted.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - req_ready is combinational: a one-hot grant to the first valid requester, searching upward from last_grant+1 with wrap.
  - Handshake = req_valid[i] & req_ready[i] at cycle T. On it: shift_reg<=req_data[i], cnt<=0, id<=i, last_grant<=i, bit_idx<=0, go to SCAN.
  - With no req_valid, stay in IDLE.
- SCAN, cycles T+1..T+VOTE_W:
  - Each cycle: cnt<=cnt+shift_reg[0], shift_reg<=shift_reg>>1, bit_idx++.
  - When bit_idx==VOTE_W-1, go to DONE. No early termination.
  - req_ready=0 throughout; new requests wait.
- DONE, from T+VOTE_W+1:
  - res_valid=1, res_count=cnt, res_out=(cnt>=THRESH), res_id=id.
  - All result outputs stay stable until res_valid&res_ready, then go to IDLE next cycle.
  - Backpressure holds DONE indefinitely.
- Latency: accept at T gives res_valid at T+VOTE_W+1 (T+8 at defaults). Peak throughput is one vote per VOTE_W+2 cycles.
- Outside DONE, res_valid=0; res_out, res_id and res_count hold their last values.
- Arithmetic: cnt is CNT_W bits unsigned and cannot overflow, since max = VOTE_W.
- Boundaries:
  - All zeros gives count 0, out 0.
  - All ones gives count VOTE_W, out 1.
  - count=THRESH gives out 1; count=THRESH-1 gives out 0.
- Fairness:
  - If all requesters hold valid, grants go 0,1,2,...,NUM_REQ-1,0.
  - A requester that drops valid before its grant is skipped without penalty.
- req_data of the granted requester is sampled only at the handshake edge. Later changes have no effect.

Decomposition:
- majority_pkg:
  - state enum {IDLE, SCAN, DONE}.
  - Default constants VOTE_W=7, NUM_REQ=4.
  - A clog2-based width function used for ID_W and CNT_W.
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: req vector, last_grant, enable.
  - Outputs: one-hot grant plus encoded index.
  - Purely combinational.
- The scheduler owns the FSM, shift register, counter and result registers.

Test Plan:
- Reset mid-SCAN:
  - Stimulus: req_valid[0]=1, data=7'd99; assert rst_n=0 at T+3.
  - Response: all outputs 0 next cycle and res_valid never rises. After release, the same request is re-granted to requester 0.
- Single requester, each word separately:
  - Stimulus: requester 0 presents 7'd99, 28, 119, 101, 32, 48, 75; res_ready=1.
  - Response (res_out/res_count): 1/4, 0/3, 1/6, 1/4, 0/1, 0/2, 1/4; res_valid exactly 8 cycles after each handshake.
- Threshold and extremes:
  - Stimulus: words 7'b0000000, 7'b1111111, 7'b0001111, 7'b0000111.
  - Response: out/count 0/0, 1/7, 1/4, 0/3.
- Round-robin contention:
  - Stimulus: all 4 requesters valid continuously with distinct words.
  - Response: res_id sequence 0,1,2,3,0,1. req_ready is never asserted outside IDLE and never has more than one bit set.
- Backpressure:
  - Stimulus: res_ready=0 for 5 cycles after res_valid, with a pending request from requester 2.
  - Response: res_valid, res_out, res_id and res_count are stable for all 5 cycles; requester 2 is granted only after the result handshake.

Source files
------------

// File: rtl/majority_pkg.sv
// Shared types and constants for the majority vote scheduler.
package majority_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_VOTE_W  = 7;
    localparam int DEF_NUM_REQ = 4;

    // Width needed to encode values 0..n-1; never narrower than one bit.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_grant+1 with
// wrap and returns a one-hot grant plus its encoded index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic            found;
    logic [ID_W-1:0] idx;

    // First valid requester after the previous winner takes the grant.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/majority_vote_scheduler.sv
// Shares one bit-serial majority evaluator among NUM_REQ requesters. A
// round-robin grant captures one vote word, the ones are counted over VOTE_W
// cycles, and the decision is presented tagged with the requester id.
module majority_vote_scheduler
    import majority_pkg::*;
#(
    parameter int  NUM_REQ = DEF_NUM_REQ,
    parameter int  VOTE_W  = DEF_VOTE_W,
    parameter int  THRESH  = (VOTE_W + 1) / 2,
    localparam int ID_W    = width_of(NUM_REQ),
    localparam int CNT_W   = width_of(VOTE_W + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*VOTE_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      res_out,
    output logic [ID_W-1:0]           res_id,
    output logic [CNT_W-1:0]          res_count,
    output logic                      busy
);

    state_t             state, state_nx;
    logic               arb_en;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               accept;
    logic [VOTE_W-1:0]  sel_word;

    logic [ID_W-1:0]    last_grant;
    logic [VOTE_W-1:0]  shift_reg;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic [CNT_W-1:0]   bit_idx;
    logic [ID_W-1:0]    id;
    logic               last_bit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .enable     (arb_en),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // A grant is only ever given to a valid requester, so any grant is a handshake.
    assign req_ready = grant;
    assign accept    = |grant;
    assign last_bit  = (bit_idx == CNT_W'(VOTE_W - 1));
    assign cnt_nx    = cnt + {{(CNT_W-1){1'b0}}, shift_reg[0]};

    // Pick the granted requester's vote word out of the flat data bus.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_word = req_data[i*VOTE_W +: VOTE_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: fixed-length scan, then hold the result until accepted.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept)    state_nx = SCAN;
            SCAN:    if (last_bit)  state_nx = DONE;
            DONE:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state; the arbiter is silenced during reset.
    always_comb begin
        arb_en    = (state == IDLE) && rst_n;
        res_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Control and result registers: priority pointer and presented decision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= ID_W'(NUM_REQ - 1);
            res_out    <= 1'b0;
            res_id     <= '0;
            res_count  <= '0;
        end else begin
            if (accept) begin
                last_grant <= grant_idx;
            end
            if (state == SCAN && last_bit) begin
                res_count <= cnt_nx;
                res_out   <= (cnt_nx >= CNT_W'(THRESH));
                res_id    <= id;
            end
        end
    end

    // Serial datapath: load the word on accept, then count one bit per cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            shift_reg <= sel_word;
            cnt       <= '0;
            bit_idx   <= '0;
            id        <= grant_idx;
        end else if (state == SCAN) begin
            shift_reg <= shift_reg >> 1;
            cnt       <= cnt_nx;
            bit_idx   <= bit_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_majority_vote_scheduler.sv
// Scoreboard bench for majority_vote_scheduler: the stimulus side queues
// hand-computed results, a negedge monitor pops and compares them.
module tb_majority_vote_scheduler;

    localparam int NUM_REQ = 4;
    localparam int VOTE_W  = 7;

    typedef struct {
        int         id;
        logic       out;
        logic [2:0] cnt;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*VOTE_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      res_valid;
    logic                      res_ready;
    logic                      res_out;
    logic [1:0]                res_id;
    logic [2:0]                res_count;
    logic                      busy;

    exp_t exp_q[$];
    int   acc_q[$];
    int   checks = 0;
    int   errs = 0;
    int   tmo = 0;
    int   tmo_seen = 0;
    int   cyc = 0;
    logic rst_low_prev = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_stall = 1'b0;
    logic       prev_out;
    logic [1:0] prev_id;
    logic [2:0] prev_count;

    majority_vote_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_out   (res_out),
        .res_id    (res_id),
        .res_count (res_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Monitor: reset state, grant legality, latency, stability and results.
    always @(negedge clk) begin
        cyc++;
        if (tmo != tmo_seen) begin
            checks += tmo - tmo_seen;
            errs   += tmo - tmo_seen;
            tmo_seen = tmo;
        end
        if (!rst_n) begin
            if (rst_low_prev) begin
                checks++;
                if (res_valid || res_out || res_id != 2'd0 || res_count != 3'd0 ||
                    busy || req_ready != '0) begin
                    errs++;
                    $display("FAIL reset_outputs: valid=%0b out=%0b id=%0d count=%0d busy=%0b ready=%b, required all zero",
                             res_valid, res_out, res_id, res_count, busy, req_ready);
                end
            end
            acc_q.delete();
            prev_valid   = 1'b0;
            prev_stall   = 1'b0;
            rst_low_prev = 1'b1;
        end else begin
            rst_low_prev = 1'b0;
            if (req_ready != '0) begin
                checks++;
                if (!$onehot(req_ready) || busy) begin
                    errs++;
                    $display("FAIL grant_legal: ready=%b busy=%0b, required one-hot while idle",
                             req_ready, busy);
                end
            end
            if (|(req_valid & req_ready)) begin
                acc_q.push_back(cyc);
            end
            if (res_valid && !prev_valid) begin
                checks++;
                if (acc_q.size() == 0) begin
                    errs++;
                    $display("FAIL latency: result at cycle %0d with no handshake, required a handshake 8 cycles earlier", cyc);
                end else begin
                    int t;
                    t = acc_q.pop_front();
                    if (cyc - t != 8) begin
                        errs++;
                        $display("FAIL latency: %0d cycles, required 8", cyc - t);
                    end
                end
            end
            if (prev_stall) begin
                checks++;
                if (!res_valid || res_out != prev_out || res_id != prev_id ||
                    res_count != prev_count) begin
                    errs++;
                    $display("FAIL stall_stable: valid=%0b out=%0b id=%0d count=%0d, required valid=1 out=%0b id=%0d count=%0d",
                             res_valid, res_out, res_id, res_count, prev_out, prev_id, prev_count);
                end
            end
            if (res_valid && res_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL result: unexpected id=%0d out=%0b count=%0d, required no result",
                             res_id, res_out, res_count);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (int'(res_id) != e.id || res_out != e.out || res_count != e.cnt) begin
                        errs++;
                        $display("FAIL result: id=%0d out=%0b count=%0d, required id=%0d out=%0b count=%0d",
                                 res_id, res_out, res_count, e.id, e.out, e.cnt);
                    end
                end
            end
            prev_valid = res_valid;
            prev_stall = res_valid && !res_ready;
            prev_out   = res_out;
            prev_id    = res_id;
            prev_count = res_count;
        end
    end

    task automatic push_exp(input int id, input logic out, input logic [2:0] cnt);
        exp_t e;
        e.id  = id;
        e.out = out;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // Wait until requester r is granted, then step past the handshake edge.
    task automatic wait_grant(input int r);
        int n;
        n = 0;
        #1;
        while (!req_ready[r]) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 300) begin
                $display("FAIL grant_timeout: requester %0d not granted after %0d cycles, required a grant", r, n);
                tmo++;
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int r, input logic [6:0] w, input logic eo, input logic [2:0] ec);
        req_data[r*VOTE_W +: VOTE_W] = w;
        req_valid[r] = 1'b1;
        push_exp(r, eo, ec);
        wait_grant(r);
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 || busy) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 500) begin
                $display("FAIL idle_timeout: %0d results outstanding, required 0", exp_q.size());
                tmo++;
                exp_q.delete();
                return;
            end
        end
    endtask

    logic [6:0] single_w [7] = '{7'd99, 7'd28, 7'd119, 7'd101, 7'd32, 7'd48, 7'd75};
    logic       single_o [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0] single_c [7] = '{3'd4, 3'd3, 3'd6, 3'd4, 3'd1, 3'd2, 3'd4};
    logic [6:0] thr_w [4] = '{7'b0000000, 7'b1111111, 7'b0001111, 7'b0000111};
    logic       thr_o [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0] thr_c [4] = '{3'd0, 3'd7, 3'd4, 3'd3};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        int n;
        rst_n     = 1'b0;
        res_ready = 1'b1;
        req_valid = '0;
        req_data  = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset during the scan abandons the vote; requester 0 is granted again.
        req_data[6:0] = 7'd99;
        req_valid[0]  = 1'b1;
        wait_grant(0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        send(0, 7'd99, 1'b1, 3'd4);
        wait_idle();

        // Single requester, one word at a time.
        for (int i = 0; i < 7; i++) begin
            send(0, single_w[i], single_o[i], single_c[i]);
        end
        wait_idle();

        // Threshold and extremes from requester 1.
        for (int i = 0; i < 4; i++) begin
            send(1, thr_w[i], thr_o[i], thr_c[i]);
        end
        wait_idle();

        // Move the priority pointer to requester 3 so contention starts at 0.
        send(3, 7'd85, 1'b1, 3'd4);
        wait_idle();

        // Round-robin contention with all four requesters held valid.
        req_data[0*VOTE_W +: VOTE_W] = 7'd99;
        req_data[1*VOTE_W +: VOTE_W] = 7'd28;
        req_data[2*VOTE_W +: VOTE_W] = 7'd119;
        req_data[3*VOTE_W +: VOTE_W] = 7'd32;
        push_exp(0, 1'b1, 3'd4);
        push_exp(1, 1'b0, 3'd3);
        push_exp(2, 1'b1, 3'd6);
        push_exp(3, 1'b0, 3'd1);
        push_exp(0, 1'b1, 3'd4);
        push_exp(1, 1'b0, 3'd3);
        req_valid = '1;
        hs = 0;
        n  = 0;
        while (hs < 6 && n < 400) begin
            #1;
            if (|(req_valid & req_ready)) hs++;
            @(posedge clk);
            n++;
        end
        #1 req_valid = '0;
        if (hs < 6) begin
            $display("FAIL rr_timeout: %0d grants, required 6", hs);
            tmo++;
        end
        wait_idle();

        // Backpressure on a result while requester 2 waits.
        res_ready = 1'b0;
        send(3, 7'd48, 1'b0, 3'd2);
        req_data[2*VOTE_W +: VOTE_W] = 7'd15;
        req_valid[2] = 1'b1;
        push_exp(2, 1'b1, 3'd4);
        n = 0;
        while (!res_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!res_valid) begin
            $display("FAIL bp_timeout: res_valid=0, required 1");
            tmo++;
        end
        repeat (5) @(posedge clk);
        #1 res_ready = 1'b1;
        wait_grant(2);
        req_valid[2] = 1'b0;
        wait_idle();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule
